// File: rtl/res_packer_pkg.sv
// Shared constants and the {word, cnt} FIFO entry type for res_out_packer.
package res_packer_pkg;
   localparam int LANE_W_DEF     = 4;
   localparam int LANES_DEF      = 8;
   localparam int FIFO_DEPTH_DEF = 4;

   localparam int WORD_W = LANE_W_DEF * LANES_DEF;
   localparam int CNT_W  = $clog2(LANES_DEF + 1);
   localparam int LVL_W  = $clog2(FIFO_DEPTH_DEF + 1);

   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [CNT_W-1:0]  cnt;
   } res_entry_t;

   // Lane index width; a single-lane packer still needs one bit.
   function automatic int idx_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction
endpackage

// File: rtl/res_out_packer_if.sv
// Packed-word output port: head-of-FIFO word, lane count, valid/ready.
interface res_out_packer_if import res_packer_pkg::*; #(
   parameter int DW = WORD_W,
   parameter int CW = CNT_W
);
   logic [DW-1:0] WORD;
   logic [CW-1:0] WORD_CNT;
   logic          WORD_VLD;
   logic          WORD_RDY;

   modport master (output WORD, WORD_CNT, WORD_VLD, input WORD_RDY);
   modport slave  (input WORD, WORD_CNT, WORD_VLD, output WORD_RDY);
endinterface

// File: rtl/res_packer_fifo.sv
// Synchronous first-word fall-through FIFO; a full FIFO accepts a push when it pops in the same cycle.
module res_packer_fifo import res_packer_pkg::*; #(
   parameter int  DEPTH   = FIFO_DEPTH_DEF,
   parameter type entry_t = res_entry_t,
   localparam int LW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  entry_t        din,
   input  logic          pop,
   output entry_t        dout,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);
   localparam int PW = $clog2(DEPTH);

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // Head reads as zero while empty so the port idles at the reset value.
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/res_out_packer.sv
// Packs RES0 output-lane nibbles into words, buffers them, flags overflow.
// Optional input register stage: define RES_PACKER_INREG_EN.
module res_out_packer import res_packer_pkg::*; #(
   parameter int  LANE_W     = LANE_W_DEF,
   parameter int  LANES      = LANES_DEF,
   parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int LVL_B      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              UserCLK,
   input  logic              RESETn,
   input  logic [LANE_W-1:0] RES_O,
   input  logic              RES_VLD,
   input  logic              FLUSH,
   input  logic              OVF_CLR,
   res_out_packer_if.master  wb,
   output logic              OVF,
   output logic [LVL_B-1:0]  LEVEL
);
   localparam int ACC_W = LANE_W * LANES;
   localparam int CNT_B = $clog2(LANES + 1);
   localparam int IDX_B = idx_w(LANES);

   typedef struct packed {
      logic [ACC_W-1:0] word;
      logic [CNT_B-1:0] cnt;
   } pack_entry_t;

   logic [LANE_W-1:0] s_dat;
   logic              s_vld, s_flush;

`ifdef RES_PACKER_INREG_EN
   logic [LANE_W-1:0] dat_q;
   logic              vld_q, flush_q;

   always_ff @(posedge UserCLK) begin
      if (!RESETn) begin
         dat_q   <= '0;
         vld_q   <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         dat_q   <= RES_O;
         vld_q   <= RES_VLD;
         flush_q <= FLUSH;
      end
   end

   assign s_dat   = dat_q;
   assign s_vld   = vld_q;
   assign s_flush = flush_q;
`else
   assign s_dat   = RES_O;
   assign s_vld   = RES_VLD;
   assign s_flush = FLUSH;
`endif

   logic [LANES-1:0][LANE_W-1:0] acc, acc_wr;
   logic [IDX_B-1:0]             idx;
   logic                         last, push;
   pack_entry_t                  push_e, head_e;
   logic                         fifo_full, fifo_empty, ovf_evt;

   // acc_wr is the accumulator with this cycle's sample merged in, so a
   // same-cycle FLUSH or completion pushes the sample along with the word.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign acc_wr[i] = (s_vld && idx == IDX_B'(i)) ? s_dat : acc[i];
   end

   assign last        = (idx == IDX_B'(LANES - 1));
   assign push        = (s_vld && last) || (s_flush && (s_vld || idx != '0));
   assign push_e.word = acc_wr;
   assign push_e.cnt  = CNT_B'(idx) + CNT_B'(s_vld);

   always_ff @(posedge UserCLK) begin
      if (!RESETn) begin
         acc <= '0;
         idx <= '0;
      end else if (push) begin
         // Clears even when the FIFO drops the word: the fabric never stalls.
         acc <= '0;
         idx <= '0;
      end else if (s_vld) begin
         acc <= acc_wr;
         idx <= idx + IDX_B'(1);
      end
   end

   res_packer_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (pack_entry_t)
   ) u_fifo (
      .clk   (UserCLK),
      .rst_n (RESETn),
      .push  (push),
      .din   (push_e),
      .pop   (wb.WORD_RDY),
      .dout  (head_e),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (LEVEL)
   );

   assign wb.WORD     = head_e.word;
   assign wb.WORD_CNT = head_e.cnt;
   assign wb.WORD_VLD = ~fifo_empty;

   // A full FIFO that pops this cycle still has room for the push.
   assign ovf_evt = push & fifo_full & ~wb.WORD_RDY;

   always_ff @(posedge UserCLK) begin
      if (!RESETn)      OVF <= 1'b0;
      else if (ovf_evt) OVF <= 1'b1;
      else if (OVF_CLR) OVF <= 1'b0;
   end
endmodule

// File: tb/tb_res_out_packer.sv
// Directed bench for res_out_packer: scoreboard of expected words, popped on WORD_VLD & WORD_RDY.
module tb_res_out_packer;
   import res_packer_pkg::*;

`ifdef RES_PACKER_INREG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic       UserCLK = 1'b0;
   logic       RESETn  = 1'b0;
   logic [3:0] RES_O   = '0;
   logic       RES_VLD = 1'b0;
   logic       FLUSH   = 1'b0;
   logic       OVF_CLR = 1'b0;
   logic       OVF;
   logic [2:0] LEVEL;

   res_out_packer_if wb ();

   res_out_packer dut (
      .UserCLK (UserCLK),
      .RESETn  (RESETn),
      .RES_O   (RES_O),
      .RES_VLD (RES_VLD),
      .FLUSH   (FLUSH),
      .OVF_CLR (OVF_CLR),
      .wb      (wb.master),
      .OVF     (OVF),
      .LEVEL   (LEVEL)
   );

   always #5 UserCLK = ~UserCLK;

   typedef struct {
      logic [31:0] w;
      logic [3:0]  c;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] wtab [6] = '{32'hDEADBEEF, 32'h01234567, 32'hA5A55A5A,
                             32'hFEDCBA98, 32'h13579BDF, 32'h2468ACE0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(posedge UserCLK);
      #1;
   endtask

   task automatic lat();
      repeat (LAT) step();
   endtask

   task automatic put(input logic [3:0] n, input logic f);
      RES_O   = n;
      RES_VLD = 1'b1;
      FLUSH   = f;
      step();
      RES_VLD = 1'b0;
      FLUSH   = 1'b0;
   endtask

   task automatic flush_only();
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
   endtask

   task automatic expect_word(input logic [31:0] w, input logic [3:0] c);
      exp_t e;
      e.w = w;
      e.c = c;
      q.push_back(e);
   endtask

   task automatic put_nibbles(input logic [31:0] w, input int n);
      for (int j = 0; j < n; j++) put(w[4*j +: 4], 1'b0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_word"},  wb.WORD, 32'h0);
      chk({tag, "_cnt"},   32'(wb.WORD_CNT), 32'h0);
      chk({tag, "_vld"},   32'(wb.WORD_VLD), 32'h0);
      chk({tag, "_ovf"},   32'(OVF), 32'h0);
      chk({tag, "_level"}, 32'(LEVEL), 32'h0);
   endtask

   // Scoreboard: every accepted word must match the oldest expectation.
   always @(negedge UserCLK) begin
      exp_t e;
      if (RESETn && wb.WORD_VLD && wb.WORD_RDY) begin
         chk("pop_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_word", wb.WORD, e.w);
            chk("sb_cnt",  32'(wb.WORD_CNT), 32'(e.c));
         end
      end
   end

   initial begin
      wb.WORD_RDY = 1'b0;
      repeat (3) step();
      chk_idle("reset");
      RESETn = 1'b1;
      step();

      // Full word 1..8, first-word latency.
      wb.WORD_RDY = 1'b1;
      expect_word(32'h87654321, 4'd8);
      put_nibbles(32'h87654321, 8);
      chk("full_vld_latency", 32'(wb.WORD_VLD), 32'(LAT == 0));
      lat();
      chk("full_vld", 32'(wb.WORD_VLD), 32'd1);
      chk("full_word", wb.WORD, 32'h87654321);
      chk("full_cnt", 32'(wb.WORD_CNT), 32'd8);
      step();
      chk("full_level_after_pop", 32'(LEVEL), 32'd0);

      // Partial word via FLUSH, then an empty FLUSH.
      expect_word(32'h00000CBA, 4'd3);
      put(4'hA, 1'b0); put(4'hB, 1'b0); put(4'hC, 1'b0);
      flush_only();
      lat();
      chk("flush_vld", 32'(wb.WORD_VLD), 32'd1);
      chk("flush_word", wb.WORD, 32'h00000CBA);
      chk("flush_cnt", 32'(wb.WORD_CNT), 32'd3);
      step();
      flush_only();
      lat();
      chk("noop_flush_vld", 32'(wb.WORD_VLD), 32'd0);
      chk("noop_flush_level", 32'(LEVEL), 32'd0);

      // Sample together with FLUSH is included.
      expect_word(32'h00000D21, 4'd3);
      put(4'h1, 1'b0); put(4'h2, 1'b0); put(4'hD, 1'b1);
      lat();
      chk("flush_smp_word", wb.WORD, 32'h00000D21);
      chk("flush_smp_cnt", 32'(wb.WORD_CNT), 32'd3);
      step();

      // Overflow: fifth word dropped, first four drain in order.
      wb.WORD_RDY = 1'b0;
      for (int k = 0; k < 4; k++) begin
         expect_word(wtab[k], 4'd8);
         put_nibbles(wtab[k], 8);
      end
      lat();
      chk("fill_level", 32'(LEVEL), 32'd4);
      chk("fill_ovf", 32'(OVF), 32'd0);
      put_nibbles(wtab[4], 8);
      lat();
      chk("ovf_level", 32'(LEVEL), 32'd4);
      chk("ovf_set", 32'(OVF), 32'd1);
      wb.WORD_RDY = 1'b1;
      repeat (4) step();
      wb.WORD_RDY = 1'b0;
      chk("drain_level", 32'(LEVEL), 32'd0);
      chk("drain_sb_empty", 32'(q.size()), 32'd0);
      chk("ovf_sticky", 32'(OVF), 32'd1);
      OVF_CLR = 1'b1;
      step();
      OVF_CLR = 1'b0;
      chk("ovf_clr", 32'(OVF), 32'd0);

      // Full FIFO: pop and completing push in the same cycle.
      for (int k = 0; k < 4; k++) begin
         expect_word(wtab[k], 4'd8);
         put_nibbles(wtab[k], 8);
      end
      expect_word(wtab[4], 4'd8);
      put_nibbles(wtab[4], 7);
      lat();
      chk("pp_pre_level", 32'(LEVEL), 32'd4);
      RES_O       = wtab[4][31:28];
      RES_VLD     = 1'b1;
      wb.WORD_RDY = (LAT == 0);
      step();
      RES_VLD = 1'b0;
      repeat (LAT) begin
         wb.WORD_RDY = 1'b1;
         step();
      end
      wb.WORD_RDY = 1'b0;
      chk("pp_level", 32'(LEVEL), 32'd4);
      chk("pp_ovf", 32'(OVF), 32'd0);

      // Overflow and OVF_CLR in the same cycle: set wins.
      put_nibbles(wtab[5], 7);
      RES_O   = wtab[5][31:28];
      RES_VLD = 1'b1;
      OVF_CLR = (LAT == 0);
      step();
      RES_VLD = 1'b0;
      repeat (LAT) begin
         OVF_CLR = 1'b1;
         step();
      end
      OVF_CLR = 1'b0;
      chk("clr_vs_set_ovf", 32'(OVF), 32'd1);
      chk("clr_vs_set_level", 32'(LEVEL), 32'd4);
      wb.WORD_RDY = 1'b1;
      repeat (4) step();
      wb.WORD_RDY = 1'b0;
      chk("drain2_level", 32'(LEVEL), 32'd0);
      chk("drain2_sb_empty", 32'(q.size()), 32'd0);

      // Mid-operation reset with a full FIFO, OVF set and a partial word.
      for (int k = 0; k < 5; k++) put_nibbles(wtab[k], 8);
      lat();
      chk("prereset_ovf", 32'(OVF), 32'd1);
      put_nibbles(32'h0000FFFF, 4);
      RESETn = 1'b0;
      q.delete();
      repeat (2) step();
      chk_idle("midreset");
      RESETn      = 1'b1;
      wb.WORD_RDY = 1'b1;
      expect_word(32'h89ABCDEF, 4'd8);
      put_nibbles(32'h89ABCDEF, 8);
      chk("post_reset_vld_latency", 32'(wb.WORD_VLD), 32'(LAT == 0));
      lat();
      chk("post_reset_word", wb.WORD, 32'h89ABCDEF);
      chk("post_reset_cnt", 32'(wb.WORD_CNT), 32'd8);
      step();
      chk("end_level", 32'(LEVEL), 32'd0);
      chk("end_sb_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
